// File: rtl/vga_frame_reader.sv
// VGA 640x480@60 reader for the dual-port frame buffer: generates timing, drives the read
// address and emits an integer-upscaled image with sync and blanking aligned to the pixels.
module vga_frame_reader #(
  parameter int AW         = 15,
  parameter int DW         = 3,
  parameter int IMG_W      = 160,
  parameter int IMG_H      = 120,
  parameter int SCALE_LOG2 = 2
) (
  input  logic          clk,
  input  logic          reset,
  output logic [AW-1:0] addr_out,
  input  logic [DW-1:0] data_in,
  output logic [DW-1:0] rgb,
  output logic          hsync,
  output logic          vsync,
  output logic          frame_start
);

  localparam logic [9:0] H_VIS      = 10'd640;
  localparam logic [9:0] H_SYNC_BEG = 10'd656;
  localparam logic [9:0] H_SYNC_END = 10'd752;
  localparam logic [9:0] H_LAST     = 10'd799;
  localparam logic [9:0] V_VIS      = 10'd480;
  localparam logic [9:0] V_SYNC_BEG = 10'd490;
  localparam logic [9:0] V_SYNC_END = 10'd492;
  localparam logic [9:0] V_LAST     = 10'd524;

  // Stage 0: raster position
  logic [9:0] h_cnt;
  logic [9:0] v_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
    end else begin
      h_cnt <= h_cnt + 10'd1;
    end
  end

  logic [31:0]   img_col;
  logic [31:0]   img_row;
  logic          vis;
  logic          in_img;
  logic          hs_n;
  logic          vs_n;
  logic          at_origin;
  logic [AW-1:0] addr_next;

  always_comb begin
    img_col   = 32'(h_cnt) >> SCALE_LOG2;
    img_row   = 32'(v_cnt) >> SCALE_LOG2;
    vis       = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    in_img    = vis && (img_col < 32'(IMG_W)) && (img_row < 32'(IMG_H));
    hs_n      = !((h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END));
    vs_n      = !((v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END));
    at_origin = (h_cnt == '0) && (v_cnt == '0);
    addr_next = '0;
    // IMG_W is a constant, so the multiply folds into shifts and adds
    if (in_img) addr_next = AW'(img_row * 32'(IMG_W) + img_col);
  end

  // Stages 1 and 2: address register plus flag delay matching the buffer's read latency
  logic img_d1, img_d2;
  logic hs_d1, hs_d2;
  logic vs_d1, vs_d2;
  logic org_d1, org_d2;

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_out <= '0;
      img_d1   <= 1'b0;
      img_d2   <= 1'b0;
      hs_d1    <= 1'b1;
      hs_d2    <= 1'b1;
      vs_d1    <= 1'b1;
      vs_d2    <= 1'b1;
      org_d1   <= 1'b0;
      org_d2   <= 1'b0;
    end else begin
      addr_out <= addr_next;
      img_d1   <= in_img;
      img_d2   <= img_d1;
      hs_d1    <= hs_n;
      hs_d2    <= hs_d1;
      vs_d1    <= vs_n;
      vs_d2    <= vs_d1;
      org_d1   <= at_origin;
      org_d2   <= org_d1;
    end
  end

  // Stage 3: output registers; data outside the image is discarded
  always_ff @(posedge clk) begin
    if (reset) begin
      rgb         <= '0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      rgb         <= img_d2 ? data_in : '0;
      hsync       <= hs_d2;
      vsync       <= vs_d2;
      frame_start <= org_d2;
    end
  end

endmodule

// File: tb/tb_vga_frame_reader.sv
// Bench for vga_frame_reader: three parameterisations against a raster-position reference
// model, a table of pixel vectors, sync width/position checks and reset corner cases.
module tb_vga_frame_reader;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // instance 0: defaults, 1: 100x60 x4, 2: 640x480 x1
  logic [14:0] addr_a;
  logic [12:0] addr_b;
  logic [18:0] addr_c;
  logic [2:0]  din_a, din_b, din_c, rgb_a, rgb_b, rgb_c;
  logic        hs_a, hs_b, hs_c, vs_a, vs_b, vs_c, fs_a, fs_b, fs_c;

  vga_frame_reader dut_a (
    .clk(clk), .reset(reset), .addr_out(addr_a), .data_in(din_a),
    .rgb(rgb_a), .hsync(hs_a), .vsync(vs_a), .frame_start(fs_a));

  vga_frame_reader #(.AW(13), .DW(3), .IMG_W(100), .IMG_H(60), .SCALE_LOG2(2)) dut_b (
    .clk(clk), .reset(reset), .addr_out(addr_b), .data_in(din_b),
    .rgb(rgb_b), .hsync(hs_b), .vsync(vs_b), .frame_start(fs_b));

  vga_frame_reader #(.AW(19), .DW(3), .IMG_W(640), .IMG_H(480), .SCALE_LOG2(0)) dut_c (
    .clk(clk), .reset(reset), .addr_out(addr_c), .data_in(din_c),
    .rgb(rgb_c), .hsync(hs_c), .vsync(vs_c), .frame_start(fs_c));

  int img_w [3] = '{160, 100, 640};
  int img_h [3] = '{120, 60, 480};
  int sl    [3] = '{2, 2, 0};

  logic [18:0] addr_o [3];
  logic [2:0]  rgb_o  [3];
  logic [2:0]  din_o  [3];
  logic        hs_o [3], vs_o [3], fs_o [3];

  assign addr_o[0] = {4'b0, addr_a};
  assign addr_o[1] = {6'b0, addr_b};
  assign addr_o[2] = addr_c;
  assign rgb_o[0] = rgb_a;
  assign rgb_o[1] = rgb_b;
  assign rgb_o[2] = rgb_c;
  assign hs_o[0] = hs_a;
  assign hs_o[1] = hs_b;
  assign hs_o[2] = hs_c;
  assign vs_o[0] = vs_a;
  assign vs_o[1] = vs_b;
  assign vs_o[2] = vs_c;
  assign fs_o[0] = fs_a;
  assign fs_o[1] = fs_b;
  assign fs_o[2] = fs_c;
  assign din_a = din_o[0];
  assign din_b = din_o[1];
  assign din_c = din_o[2];

  logic [2:0] mem_b [8192];

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input int k, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      if (n_errors <= 40)
        $display("FAIL %s inst%0d t=%0t: got %0d expected %0d", name, k, $time, act, exp);
    end
  endtask

  // Reference model: frame position per cycle, delayed by the pixel pipeline
  typedef struct {
    bit valid;
    int h;
    int v;
  } rec_t;

  rec_t pipe [3][3];
  int   pos  [3] = '{0, 0, 0};

  function automatic logic [2:0] mem_val(input int k, input int a);
    logic [31:0] av;
    av = a;
    if (k == 0) return av[2:0];
    if (k == 1) return (a >= 0 && a < 8192) ? mem_b[a] : 3'd0;
    return av[2:0] ^ av[5:3];
  endfunction

  function automatic bit rec_in_img(input int k, input rec_t r);
    return r.valid && r.h < 640 && r.v < 480 &&
           (r.h >> sl[k]) < img_w[k] && (r.v >> sl[k]) < img_h[k];
  endfunction

  function automatic int pix_addr(input int k, input rec_t r);
    return (r.v >> sl[k]) * img_w[k] + (r.h >> sl[k]);
  endfunction

  function automatic int exp_addr(input int k, input rec_t r);
    return rec_in_img(k, r) ? pix_addr(k, r) : 0;
  endfunction

  function automatic int exp_rgb(input int k, input rec_t r);
    return rec_in_img(k, r) ? int'(mem_val(k, pix_addr(k, r))) : 0;
  endfunction

  function automatic int exp_hs(input rec_t r);
    return (r.valid && r.h >= 656 && r.h < 752) ? 0 : 1;
  endfunction

  function automatic int exp_vs(input rec_t r);
    return (r.valid && r.v >= 490 && r.v < 492) ? 0 : 1;
  endfunction

  function automatic int exp_fs(input rec_t r);
    return (r.valid && r.h == 0 && r.v == 0) ? 1 : 0;
  endfunction

  // Buffer model (1-cycle registered read) and model advance
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rec_in_img(k, pipe[k][0]))
        din_o[k] <= mem_val(k, int'(addr_o[k]));
      else
        din_o[k] <= 3'($urandom_range(1, 7));
      if (reset) begin
        for (int s = 0; s < 3; s++) pipe[k][s].valid = 1'b0;
        pos[k] = 0;
      end else begin
        pipe[k][2] = pipe[k][1];
        pipe[k][1] = pipe[k][0];
        pipe[k][0].valid = 1'b1;
        pipe[k][0].h = pos[k] % 800;
        pipe[k][0].v = pos[k] / 800;
        pos[k] = (pos[k] + 1) % 420000;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 3; k++) begin
        check("addr", k, int'(addr_o[k]), exp_addr(k, pipe[k][0]));
        check("rgb", k, int'(rgb_o[k]), exp_rgb(k, pipe[k][2]));
        check("hsync", k, int'(hs_o[k]), exp_hs(pipe[k][2]));
        check("vsync", k, int'(vs_o[k]), exp_vs(pipe[k][2]));
        check("frame_start", k, int'(fs_o[k]), exp_fs(pipe[k][2]));
      end
    end
  end

  // Move every instance's raster position; call just after a falling edge
  logic [9:0] jh, jv;
  task automatic jump(input logic [9:0] h, input logic [9:0] v);
    jh = h;
    jv = v;
    force dut_a.h_cnt = jh;
    force dut_a.v_cnt = jv;
    force dut_b.h_cnt = jh;
    force dut_b.v_cnt = jv;
    force dut_c.h_cnt = jh;
    force dut_c.v_cnt = jv;
    for (int k = 0; k < 3; k++) pos[k] = int'(v) * 800 + int'(h);
    #1;
    release dut_a.h_cnt;
    release dut_a.v_cnt;
    release dut_b.h_cnt;
    release dut_b.v_cnt;
    release dut_c.h_cnt;
    release dut_c.v_cnt;
  endtask

  task automatic check_reset_state(input string tag);
    for (int k = 0; k < 3; k++) begin
      check({tag, "_addr"}, k, int'(addr_o[k]), 0);
      check({tag, "_rgb"}, k, int'(rgb_o[k]), 0);
      check({tag, "_hsync"}, k, int'(hs_o[k]), 1);
      check({tag, "_vsync"}, k, int'(vs_o[k]), 1);
      check({tag, "_fs"}, k, int'(fs_o[k]), 0);
    end
  endtask

  // frame_start must rise on the third edge after reset is released
  task automatic fs_after_release(input string tag);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) check(tag, k, int'(fs_o[k]), (i == 3) ? 1 : 0);
    end
  endtask

  typedef struct {
    int k;
    int h;
    int v;
    int addr;
    int rgb;
  } vec_t;

  vec_t vecs [13];

  initial begin
    int t_fall1, t_rise, t_fall2, prev;
    int vs_fall, vs_low, fs_at, fs_cnt;
    int n, rp;

    reset = 1'b1;
    for (int i = 0; i < 8192; i++) mem_b[i] = 3'($urandom_range(0, 7));

    vecs[0]  = '{0, 8, 4, 162, 2};
    vecs[1]  = '{0, 639, 479, 19199, 7};
    vecs[2]  = '{0, 640, 100, 0, 0};
    vecs[3]  = '{0, 100, 480, 0, 0};
    vecs[4]  = '{0, 4, 0, 1, 1};
    vecs[5]  = '{1, 399, 239, 5999, int'(mem_b[5999])};
    vecs[6]  = '{1, 400, 10, 0, 0};
    vecs[7]  = '{1, 10, 240, 0, 0};
    vecs[8]  = '{1, 4, 4, 101, int'(mem_b[101])};
    vecs[9]  = '{2, 5, 1, 645, 5};
    vecs[10] = '{2, 639, 479, 307199, 0};
    vecs[11] = '{2, 3, 0, 3, 3};
    vecs[12] = '{2, 700, 3, 0, 0};

    repeat (4) @(negedge clk);
    check_reset_state("reset");
    chk_en = 1'b1;
    reset = 1'b0;
    fs_after_release("fs_first");

    // hsync width and period
    t_fall1 = -1; t_rise = -1; t_fall2 = -1; prev = 1;
    for (int c = 0; c < 3000 && t_fall2 < 0; c++) begin
      @(negedge clk);
      if (prev == 1 && !hs_a) begin
        if (t_fall1 < 0) t_fall1 = c;
        else t_fall2 = c;
      end
      if (prev == 0 && hs_a && t_fall1 >= 0 && t_rise < 0) t_rise = c;
      prev = int'(hs_a);
    end
    check("hsync_low_width", 0, t_rise - t_fall1, 96);
    check("hsync_period", 0, t_fall2 - t_fall1, 800);

    // pixel vectors
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      jump(10'(vecs[i].h), 10'(vecs[i].v));
      @(negedge clk);
      check("vec_addr", vecs[i].k, int'(addr_o[vecs[i].k]), vecs[i].addr);
      repeat (2) @(negedge clk);
      check("vec_rgb", vecs[i].k, int'(rgb_o[vecs[i].k]), vecs[i].rgb);
    end

    // vsync width and frame wrap, starting from line 486
    @(negedge clk);
    jump(10'd0, 10'd486);
    vs_fall = -1; vs_low = 0; fs_at = -1; fs_cnt = 0; prev = 1;
    for (int c = 0; c < 33000; c++) begin
      @(negedge clk);
      if (prev == 1 && !vs_a && vs_fall < 0) vs_fall = c;
      if (!vs_a) vs_low++;
      if (fs_a) begin
        fs_cnt++;
        if (fs_at < 0) fs_at = c;
      end
      prev = int'(vs_a);
    end
    check("vsync_fall_at", 0, vs_fall, 3202);
    check("vsync_low_width", 0, vs_low, 1600);
    check("frame_start_at", 0, fs_at, 31202);
    check("frame_start_count", 0, fs_cnt, 1);

    // one-cycle reset at (300,200)
    @(negedge clk);
    jump(10'd295, 10'd200);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_state("midreset");
    reset = 1'b0;
    fs_after_release("fs_midreset");

    // reset while both syncs are asserted
    @(negedge clk);
    jump(10'd700, 10'd491);
    repeat (3) @(negedge clk);
    check("sync_pre_hs", 0, int'(hs_a), 0);
    check("sync_pre_vs", 0, int'(vs_a), 0);
    reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check_reset_state("syncreset");
    end
    reset = 1'b0;
    fs_after_release("fs_syncreset");

    // random positions with occasional reset pulses
    for (int it = 0; it < 20; it++) begin
      @(negedge clk);
      jump(10'($urandom_range(0, 799)), 10'($urandom_range(0, 524)));
      n = int'($urandom_range(50, 1200));
      rp = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, n - 1)) : -1;
      for (int c = 0; c < n; c++) begin
        @(negedge clk);
        reset = (c == rp);
      end
      reset = 1'b0;
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
